d_cmp_pipe: RTL and testbench
=============================

# d_cmp_pipe

Parametrised, registered branch-condition comparator for the decode stage of the pipelined MIPS core. It evaluates one of eight compare modes between `rs` and `rt` (or `rs` against zero) and registers the result with one cycle of latency. It honours the pipeline's stall and flush controls and keeps saturating taken/total branch statistics counters for the performance-counter path.

## Interface
- `WIDTH`, 32: operand width in bits (≥2).
- `CNT_W`, 16: width of each statistics counter (≥1).

- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a branch instruction with ready operands is presented this cycle.
- `stall`  in  1  decode stall; hold all registered state.
- `flush`  in  1  kill the output stage.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `mode`  in  3  compare mode, see Operation.
- `rs`  in  WIDTH  first operand (already forwarded).
- `rt`  in  WIDTH  second operand (already forwarded).
- `out_valid`  out  1  registered: `cmp_result` belongs to a captured branch.
- `cmp_result`  out  1  registered condition result, 1 = taken.
- `taken_cnt`  out  CNT_W  count of captured branches with result 1.
- `total_cnt`  out  CNT_W  count of captured branches.

## Operation
- Modes: 000 EQ (rs==rt); 001 NE (rs!=rt); 010 LEZ (signed rs≤0); 011 GTZ (signed rs>0); 100 LTZ (rs[WIDTH-1]==1); 101 GEZ (rs[WIDTH-1]==0); 110 LTU (rs<rt unsigned); 111 LT (rs<rt signed, two's complement). `rt` is ignored in modes 010–101.
- Combinational condition `c` computed from the current inputs; no internal arithmetic wider than WIDTH+1 bits.
- Priority per clock edge: reset > flush > stall > capture.
  - reset: `out_valid`=0, `cmp_result`=0, `taken_cnt`=0, `total_cnt`=0.
  - flush: `out_valid`=0, `cmp_result`=0; input not captured, not counted; counters otherwise follow the `cnt_clr` rule.
  - stall (no flush): `out_valid`, `cmp_result` hold; input not counted.
  - capture: `out_valid`<=`in_valid`; `cmp_result`<=`in_valid` & `c`.
- Counters: on capture with `in_valid`=1, `total_cnt` +1 and, if `c`=1, `taken_cnt` +1. Each counter saturates at 2^CNT_W−1 independently; it never wraps.
- `cnt_clr`=1 (and not reset) forces both counters to 0 regardless of flush/stall/capture; a coincident capture is not counted.
- With `in_valid`=0 on capture, `cmp_result` is forced to 0 and counters hold.

## Timing
- Latency: inputs sampled at edge N appear on `out_valid`/`cmp_result` after edge N; counters reflect that capture after the same edge.
- Throughput: one branch per cycle when not stalled.
- Outputs are purely registered; no combinational path from any input to any output.
- Reset mid-stall or mid-flush: reset wins, all outputs 0 after the edge.
- Stall released: the first unstalled edge captures the inputs present in that cycle. Held values are not re-counted.
- Simultaneous stall+flush: flush wins, `out_valid`=0.

## Test plan
- Reset, then EQ with rs=rt=0x1234_5678 and in_valid=1 -> next cycle `out_valid`=1, `cmp_result`=1, `total_cnt`=1, `taken_cnt`=1; NE with the same operands -> `cmp_result`=0, `total_cnt`=2, `taken_cnt`=1.
- Sign modes, WIDTH=32: rs=0x8000_0000 -> LTZ=1, LEZ=1, GEZ=0, GTZ=0; rs=0 -> LEZ=1, GEZ=1, GTZ=0, LTZ=0; rs=1 -> GTZ=1.
- LT vs LTU with rs=0xFFFF_FFFF, rt=1 -> LT result 1, LTU result 0.
- Capture EQ-taken, then assert stall for 3 cycles while changing operands -> `cmp_result`=1 and `total_cnt` unchanged throughout. Assert stall+flush -> `out_valid`=0, `cmp_result`=0.
- CNT_W=2: seven taken branches back to back -> `total_cnt` and `taken_cnt` stick at 3. Then `cnt_clr` coincident with in_valid=1 -> both counters 0 next cycle, `out_valid`=1.
- Assert reset during a valid, stalled stream -> all four outputs 0 after the edge. After reset deasserts, a new capture starts counting from 1.

Source files
------------

// File: rtl/d_cmp_pipe.sv
// d_cmp_pipe: registered branch-condition comparator for decode.
// One-cycle latency, stall/flush aware, saturating branch statistics.
module d_cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             out_valid,
    output logic             cmp_result,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] total_cnt
);

    localparam logic [2:0] M_EQ  = 3'b000;
    localparam logic [2:0] M_NE  = 3'b001;
    localparam logic [2:0] M_LEZ = 3'b010;
    localparam logic [2:0] M_GTZ = 3'b011;
    localparam logic [2:0] M_LTZ = 3'b100;
    localparam logic [2:0] M_GEZ = 3'b101;
    localparam logic [2:0] M_LTU = 3'b110;
    localparam logic [2:0] M_LT  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic eq;
    logic neg;
    logic zero;
    logic ltu;
    logic lt;
    logic c;
    logic capture;

    assign eq   = (rs == rt);
    assign neg  = rs[WIDTH-1];
    assign zero = (rs == '0);
    assign ltu  = (rs < rt);
    assign lt   = ($signed(rs) < $signed(rt));

    assign capture = in_valid & ~flush & ~stall;

    // Select the branch condition for the requested compare mode
    always_comb begin
        c = 1'b0;
        unique case (mode)
            M_EQ:    c = eq;
            M_NE:    c = ~eq;
            M_LEZ:   c = neg | zero;
            M_GTZ:   c = ~neg & ~zero;
            M_LTZ:   c = neg;
            M_GEZ:   c = ~neg;
            M_LTU:   c = ltu;
            M_LT:    c = lt;
            default: c = 1'b0;
        endcase
    end

    // Output stage: flush kills, stall holds, otherwise capture
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            cmp_result <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            cmp_result <= 1'b0;
        end else if (!stall) begin
            out_valid  <= in_valid;
            cmp_result <= in_valid & c;
        end
    end

    // Saturating statistics; clear overrides any coincident capture
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            taken_cnt <= '0;
            total_cnt <= '0;
        end else if (capture) begin
            if (total_cnt != CNT_MAX) begin
                total_cnt <= total_cnt + 1'b1;
            end
            if (c && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_d_cmp_pipe.sv
// tb_d_cmp_pipe: randomized and directed checks of d_cmp_pipe
// against a behavioural model, at CNT_W=16 and CNT_W=2.
module tb_d_cmp_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;

    logic        ov, cr, ov2, cr2;
    logic [15:0] tk, tt;
    logic [1:0]  tk2, tt2;

    int total = 0;
    int bad = 0;

    bit e_ov, e_cr;
    int e_tk, e_tt, e_tk2, e_tt2;

    always #5 clk = ~clk;

    d_cmp_pipe #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .mode(mode), .rs(rs), .rt(rt),
        .out_valid(ov), .cmp_result(cr),
        .taken_cnt(tk), .total_cnt(tt)
    );

    d_cmp_pipe #(.WIDTH(32), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .mode(mode), .rs(rs), .rt(rt),
        .out_valid(ov2), .cmp_result(cr2),
        .taken_cnt(tk2), .total_cnt(tt2)
    );

    function automatic bit ref_cond(input logic [2:0] m,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = a[31] ? ua - 64'h1_0000_0000 : ua;
        longint sb = b[31] ? ub - 64'h1_0000_0000 : ub;
        case (m)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd2: return sa <= 0;
            3'd3: return sa > 0;
            3'd4: return sa < 0;
            3'd5: return sa >= 0;
            3'd6: return ua < ub;
            default: return sa < sb;
        endcase
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    // Advance the model by one edge using the present inputs, then clock
    task automatic tick();
        bit c;
        bit counted;
        c = ref_cond(mode, rs, rt);
        counted = in_valid && !flush && !stall;
        if (reset) begin
            e_ov = 0; e_cr = 0;
            e_tk = 0; e_tt = 0; e_tk2 = 0; e_tt2 = 0;
        end else begin
            if (flush) begin
                e_ov = 0; e_cr = 0;
            end else if (!stall) begin
                e_ov = in_valid; e_cr = in_valid && c;
            end
            if (cnt_clr) begin
                e_tk = 0; e_tt = 0; e_tk2 = 0; e_tt2 = 0;
            end else if (counted) begin
                e_tt = sat_inc(e_tt, 65535);
                e_tt2 = sat_inc(e_tt2, 3);
                if (c) begin
                    e_tk = sat_inc(e_tk, 65535);
                    e_tk2 = sat_inc(e_tk2, 3);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] m,
                         input logic [31:0] a,
                         input logic [31:0] b);
        reset = 0; stall = 0; flush = 0; cnt_clr = 0;
        in_valid = v; mode = m; rs = a; rt = b;
    endtask

    task automatic test_reset();
        drive(1, 3'd0, 32'h5, 32'h5);
        reset = 1;
        tick();
        total++;
        if ({ov, cr, tt, tk} !== {1'b0, 1'b0, 16'd0, 16'd0}) begin
            bad++;
            $display("FAIL reset got=%b/%b/%0d/%0d exp=0/0/0/0",
                     ov, cr, tt, tk);
        end
        total++;
        if ({ov2, cr2, tt2, tk2} !== 6'd0) begin
            bad++;
            $display("FAIL reset2 got=%b/%b/%0d/%0d exp=0",
                     ov2, cr2, tt2, tk2);
        end
    endtask

    task automatic test_eq_ne();
        drive(1, 3'd0, 32'h1234_5678, 32'h1234_5678);
        tick();
        total++;
        if ({ov, cr, tt, tk} !== {1'b1, 1'b1, 16'd1, 16'd1}) begin
            bad++;
            $display("FAIL eq got=%b/%b/%0d/%0d exp=1/1/1/1",
                     ov, cr, tt, tk);
        end
        drive(1, 3'd1, 32'h1234_5678, 32'h1234_5678);
        tick();
        total++;
        if ({ov, cr, tt, tk} !== {1'b1, 1'b0, 16'd2, 16'd1}) begin
            bad++;
            $display("FAIL ne got=%b/%b/%0d/%0d exp=1/0/2/1",
                     ov, cr, tt, tk);
        end
    endtask

    task automatic test_sign_modes();
        logic [31:0] va [9] = '{32'h8000_0000, 32'h8000_0000,
                                32'h8000_0000, 32'h8000_0000,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
        logic [2:0]  vm [9] = '{3'd4, 3'd2, 3'd5, 3'd3,
                                3'd2, 3'd5, 3'd3, 3'd4, 3'd3};
        bit          ve [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
        for (int i = 0; i < 9; i++) begin
            drive(1, vm[i], va[i], $urandom);
            tick();
            total++;
            if (cr !== ve[i] || cr !== e_cr) begin
                bad++;
                $display("FAIL sign[%0d] mode=%0d rs=%h got=%b exp=%b",
                         i, vm[i], va[i], cr, ve[i]);
            end
        end
    endtask

    task automatic test_lt_ltu();
        drive(1, 3'd7, 32'hFFFF_FFFF, 32'h1);
        tick();
        total++;
        if (cr !== 1'b1) begin
            bad++;
            $display("FAIL lt got=%b exp=1", cr);
        end
        drive(1, 3'd6, 32'hFFFF_FFFF, 32'h1);
        tick();
        total++;
        if (cr !== 1'b0) begin
            bad++;
            $display("FAIL ltu got=%b exp=0", cr);
        end
    endtask

    task automatic test_stall_flush();
        int held;
        drive(1, 3'd0, 32'hABCD, 32'hABCD);
        tick();
        held = e_tt;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'($urandom_range(0, 7)), $urandom, $urandom);
            stall = 1;
            tick();
            total++;
            if (ov !== 1'b1 || cr !== 1'b1 || int'(tt) != held) begin
                bad++;
                $display("FAIL stall[%0d] got=%b/%b/%0d exp=1/1/%0d",
                         i, ov, cr, tt, held);
            end
        end
        drive(1, 3'd0, 32'h7, 32'h7);
        stall = 1;
        flush = 1;
        tick();
        total++;
        if ({ov, cr, tt} !== {1'b0, 1'b0, 16'(held)}) begin
            bad++;
            $display("FAIL stall_flush got=%b/%b/%0d exp=0/0/%0d",
                     ov, cr, tt, held);
        end
    endtask

    task automatic test_saturate();
        drive(0, 3'd0, 0, 0);
        reset = 1;
        tick();
        for (int i = 1; i <= 7; i++) begin
            drive(1, 3'd0, 32'(i), 32'(i));
            tick();
            total++;
            if (int'(tt2) != (i > 3 ? 3 : i) ||
                int'(tk2) != (i > 3 ? 3 : i)) begin
                bad++;
                $display("FAIL sat[%0d] got=%0d/%0d exp=%0d",
                         i, tt2, tk2, (i > 3 ? 3 : i));
            end
        end
        drive(1, 3'd0, 32'h9, 32'h9);
        cnt_clr = 1;
        tick();
        total++;
        if ({ov2, tt2, tk2, tt, tk} !== {1'b1, 2'd0, 2'd0, 16'd0, 16'd0}) begin
            bad++;
            $display("FAIL clr got=%b/%0d/%0d/%0d/%0d exp=1/0/0/0/0",
                     ov2, tt2, tk2, tt, tk);
        end
    endtask

    task automatic test_reset_mid_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd0, 32'h3, 32'h3);
            tick();
        end
        drive(1, 3'd0, 32'h3, 32'h3);
        stall = 1;
        tick();
        stall = 1;
        reset = 1;
        tick();
        total++;
        if ({ov, cr, tt, tk} !== 34'd0) begin
            bad++;
            $display("FAIL rst_stall got=%b/%b/%0d/%0d exp=0/0/0/0",
                     ov, cr, tt, tk);
        end
        drive(1, 3'd0, 32'h4, 32'h4);
        tick();
        total++;
        if ({ov, cr, tt, tk} !== {1'b1, 1'b1, 16'd1, 16'd1}) begin
            bad++;
            $display("FAIL rst_restart got=%b/%b/%0d/%0d exp=1/1/1/1",
                     ov, cr, tt, tk);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  a, ($urandom_range(0, 3) == 0) ? a : $urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            cnt_clr = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
            total++;
            if ({ov, cr, tt, tk} !==
                {e_ov, e_cr, 16'(e_tt), 16'(e_tk)}) begin
                bad++;
                $display("FAIL rand[%0d] got=%b/%b/%0d/%0d exp=%b/%b/%0d/%0d",
                         i, ov, cr, tt, tk, e_ov, e_cr, e_tt, e_tk);
            end
            total++;
            if ({ov2, cr2, tt2, tk2} !==
                {e_ov, e_cr, 2'(e_tt2), 2'(e_tk2)}) begin
                bad++;
                $display("FAIL rand2[%0d] got=%b/%b/%0d/%0d exp=%b/%b/%0d/%0d",
                         i, ov2, cr2, tt2, tk2, e_ov, e_cr, e_tt2, e_tk2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_eq_ne();
        test_sign_modes();
        test_lt_ltu();
        test_stall_flush();
        test_saturate();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
